sfp_i2c_target: RTL and testbench
=================================

# sfp_i2c_target

I2C target (responder) exposing both SFP cages' status and control pins as a small register file on the board-management I2C bus (`i2c_fpga_scl`/`i2c_fpga_sda`). An external controller (BMC or test host) is the initiator. It reads module-present and loss-of-signal state, and writes the rate-select, TX-disable and LED values that the top level otherwise ties to constants. The block sits between the top-level open-drain pads and the SFP control outputs.

## Interface
- `DEV_ADDR`, 7'h42: 7-bit target address.
- `DEVICE_ID`, 8'hC1: read-only value of register 0x00.
- `FILTER_LEN`, 4: number of consecutive stable `clk` samples required to accept a new SCL/SDA level.
- `clk` in 1: system clock, 100 MHz nominal; must be ≥ 25× the SCL rate.
- `nrst` in 1: asynchronous, active-low reset.
- `scl_i` in 1: SCL pad input.
- `sda_i` in 1: SDA pad input.
- `sda_oe` out 1: 1 = pull SDA low. The top level drives the pad to `sda_oe ? 1'b0 : 1'bz`.
- `sfp1_mod_abs`, `sfp1_rxlos`, `sfp2_mod_abs`, `sfp2_rxlos` in 1 each: asynchronous status inputs.
- `ctrl` out 8: control register. Bits [0] sfp1_rs0, [1] sfp1_rs1, [2] sfp1_tx_dis_force, [4] sfp2_rs0, [5] sfp2_rs1, [6] sfp2_tx_dis_force.
- `led` out 4: LED register bits [3:0].

## Operation
- SCL and SDA each pass through a 2-FF synchronizer and then a glitch filter of `FILTER_LEN` samples. All protocol logic uses the filtered levels and edges only.
- START = filtered SDA falls while SCL is high. STOP = filtered SDA rises while SCL is high. Both are detected in every state.
- STOP returns the FSM to IDLE. START, including a repeated START, always enters ADDR.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
- Data bits are sampled on the filtered SCL rising edge, MSB first.
- ADDR: after 8 bits, an address match goes to ADDR_ACK and drives ACK. A mismatch goes to IGNORE, and `sda_oe` stays 0 until the next START or STOP.
- Write path: the first byte after the address is the register pointer (PTR), and the target ACKs it. Each following byte is written to `reg[ptr]` at its 8th rising edge, then ACKed, then `ptr` increments.
- Read path: the byte at `reg[ptr]` is snapshotted on the SCL falling edge that ends ADDR_ACK, then shifted out; `ptr` increments.
- RD_ACK: the initiator's ACK (SDA low) is sampled on the rising edge. ACK loads the next byte. NACK releases SDA and goes to IGNORE.
- The pointer is 3 bits and wraps 0x07→0x00. It persists across transactions and resets to 0.
- Register map:
  - 0x00: `DEVICE_ID`, read-only.
  - 0x01: {6'b0, sfp1_rxlos, sfp1_mod_abs}, synchronized, read-only.
  - 0x02: the same layout for SFP2.
  - 0x03: `ctrl`, R/W, reset 8'h33 (rate-select high, TX not forced off). Writes to bits 3 and 7 are ignored; those bits read 0.
  - 0x04: {4'b0, led}, R/W, reset 0.
  - 0x05: event register (see Configuration).
  - 0x06–0x07: read 0; writes are ignored but still ACKed.
- No clock stretching: SCL is never driven.

## Timing
- Reset values: `sda_oe`=0, `ctrl`=8'h33, `led`=0, pointer=0, FSM=IDLE.
- `nrst` asserted mid-transfer releases SDA asynchronously. After reset the block waits for a fresh START.
- Edge-detect latency from pad to internal edge = 2 + `FILTER_LEN` cycles.
- `sda_oe` changes exactly one cycle after the internal SCL falling edge. That is 7 cycles (70 ns) at defaults, which is inside the I2C tHD;DAT limit.
- ACK: `sda_oe`=1 from the falling edge after bit 8 until the falling edge after bit 9.
- `ctrl`/`led` update one cycle after the internal 8th rising edge of the data byte.
- Status bits are synchronized with 2 FFs. A read returns the value at snapshot time; the byte does not change mid-byte.
- START/STOP arriving mid-byte: the partial byte is discarded, no register is written, and `sda_oe` drops next cycle.

## Configuration
- `SFP_I2C_TARGET_EVENT_EN` defined:
  - Register 0x05 = {sfp2_rxlos_chg, sfp2_abs_chg, 2'b0, ..., sfp1_rxlos_chg, sfp1_abs_chg} at bits [5:4] and [1:0].
  - Each bit is sticky, set on any edge of the synchronized input.
  - All bits clear on the cycle the byte is snapshotted for a read. An event arriving in that same cycle stays set.
- Undefined: 0x05 reads 0 and no event logic is instantiated.

## Structure
- Package `sfp_i2c_pkg`: FSM state enum, register address localparams (REG_ID..REG_EVT), `CTRL_RESET` = 8'h33, and `ctrl` bit-index constants.
- One sub-module, `i2c_line_filter`: 2-FF synchronizer plus `FILTER_LEN` stability counter. It is instantiated for SCL and for SDA and outputs the level plus rise/fall strobes.

## Test plan
- Write [0x84 W, 0x03, 0x05] then STOP → three ACKs, `ctrl`=8'h05, `led` unchanged.
- Write pointer 0x00, repeated START, [0x85 R], read 2 bytes ACK/NACK with sfp1_mod_abs=1 → 0xC1, 0x01; SDA released after NACK.
- Address 0x90 → no ACK, `sda_oe` never 1, registers unchanged.
- Read from pointer 0x07 for 2 bytes → 0x00, then 0xC1 (wrap).
- 2-cycle low glitch on SCL mid-byte → ignored, byte received correctly.
- Assert `nrst` while the target drives a 0 data bit → `sda_oe`=0 immediately, `ctrl`=8'h33. With `SFP_I2C_TARGET_EVENT_EN`: toggle sfp2_rxlos, read 0x05 twice → 0x20, then 0x00.

Source files
------------

// File: rtl/sfp_i2c_pkg.sv
// Shared types and constants for the SFP board-management I2C target.
// Holds the protocol FSM encoding, register map addresses and ctrl bit layout.
package sfp_i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR,
    WR_ACK,
    RD,
    RD_ACK,
    IGNORE
  } i2c_state_e;

  localparam logic [2:0] REG_ID   = 3'd0;
  localparam logic [2:0] REG_SFP1 = 3'd1;
  localparam logic [2:0] REG_SFP2 = 3'd2;
  localparam logic [2:0] REG_CTRL = 3'd3;
  localparam logic [2:0] REG_LED  = 3'd4;
  localparam logic [2:0] REG_EVT  = 3'd5;

  localparam logic [7:0] CTRL_RESET = 8'h33;

  localparam int CTRL_SFP1_RS0     = 0;
  localparam int CTRL_SFP1_RS1     = 1;
  localparam int CTRL_SFP1_TX_DIS  = 2;
  localparam int CTRL_SFP2_RS0     = 4;
  localparam int CTRL_SFP2_RS1     = 5;
  localparam int CTRL_SFP2_TX_DIS  = 6;

  // Only the defined control bits are writable; bits 3 and 7 always read 0.
  localparam logic [7:0] CTRL_WR_MASK = 8'((1 << CTRL_SFP1_RS0) | (1 << CTRL_SFP1_RS1) |
                                           (1 << CTRL_SFP1_TX_DIS) | (1 << CTRL_SFP2_RS0) |
                                           (1 << CTRL_SFP2_RS1) | (1 << CTRL_SFP2_TX_DIS));

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizes one I2C pad line and accepts a new level only after FILTER_LEN
// consecutive stable samples; emits one-cycle rise/fall strobes with the level.
module i2c_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;
  logic          level_reg;
  logic          rise_reg;
  logic          fall_reg;

  // Idle bus is high, so the pipeline resets to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_reg  <= 2'b11;
      cnt_reg   <= '0;
      level_reg <= 1'b1;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], din};
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      if (sync_reg[1] == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(FILTER_LEN - 1)) begin
        level_reg <= sync_reg[1];
        rise_reg  <= sync_reg[1];
        fall_reg  <= ~sync_reg[1];
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/sfp_i2c_target.sv
// I2C target exposing SFP status/control pins as an 8-entry register file.
// Define SFP_I2C_TARGET_EVENT_EN to enable the sticky change-event register 0x05.
module sfp_i2c_target
  import sfp_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h42,
  parameter logic [7:0] DEVICE_ID  = 8'hC1,
  parameter int         FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic       sfp1_mod_abs,
  input  logic       sfp1_rxlos,
  input  logic       sfp2_mod_abs,
  input  logic       sfp2_rxlos,
  output logic [7:0] ctrl,
  output logic [3:0] led
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .nrst(nrst), .din(scl_i), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );
  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .nrst(nrst), .din(sda_i), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  logic start, stop;
  assign start = sda_fall & scl_lvl;
  assign stop  = sda_rise & scl_lvl;

  // Status order: [0] sfp1_mod_abs, [1] sfp1_rxlos, [2] sfp2_mod_abs, [3] sfp2_rxlos.
  logic [3:0] stat_async, stat_s;
  assign stat_async = {sfp2_rxlos, sfp2_mod_abs, sfp1_rxlos, sfp1_mod_abs};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_stat_sync
      logic [1:0] s_reg;
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) s_reg <= 2'b00;
        else       s_reg <= {s_reg[0], stat_async[gi]};
      end
      assign stat_s[gi] = s_reg[1];
    end
  endgenerate

  i2c_state_e state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [6:0] shift_reg, shift_next;
  logic [6:0] tx_reg, tx_next;
  logic [2:0] ptr_reg, ptr_next;
  logic       rw_reg, rw_next;
  logic       ack_on_reg, ack_on_next;
  logic       sda_oe_reg, sda_oe_next;
  logic [7:0] ctrl_reg, ctrl_next;
  logic [3:0] led_reg, led_next;
  logic [7:0] rx_byte, rd_byte, evt_byte;
  logic       snap;

`ifdef SFP_I2C_TARGET_EVENT_EN
  logic [3:0] stat_prev_reg;
  logic [3:0] evt_reg;
  logic       evt_clr;
  assign evt_clr = snap & (ptr_reg == REG_EVT);

  // A change in the clearing cycle is OR-ed in after the clear, so it survives.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stat_prev_reg <= 4'b0000;
      evt_reg       <= 4'b0000;
    end else begin
      stat_prev_reg <= stat_s;
      evt_reg       <= (evt_clr ? 4'b0000 : evt_reg) | (stat_s ^ stat_prev_reg);
    end
  end
  assign evt_byte = {2'b00, evt_reg[3:2], 2'b00, evt_reg[1:0]};
`else
  assign evt_byte = 8'h00;
`endif

  always_comb begin
    rd_byte = 8'h00;
    case (ptr_reg)
      REG_ID:   rd_byte = DEVICE_ID;
      REG_SFP1: rd_byte = {6'b0, stat_s[1], stat_s[0]};
      REG_SFP2: rd_byte = {6'b0, stat_s[3], stat_s[2]};
      REG_CTRL: rd_byte = ctrl_reg;
      REG_LED:  rd_byte = {4'b0, led_reg};
      REG_EVT:  rd_byte = evt_byte;
      default:  rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= '0;
      ptr_reg     <= '0;
      rw_reg      <= 1'b0;
      ack_on_reg  <= 1'b0;
      sda_oe_reg  <= 1'b0;
      ctrl_reg    <= CTRL_RESET;
      led_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
      ptr_reg     <= ptr_next;
      rw_reg      <= rw_next;
      ack_on_reg  <= ack_on_next;
      sda_oe_reg  <= sda_oe_next;
      ctrl_reg    <= ctrl_next;
      led_reg     <= led_next;
    end
  end

  // ack_on marks the second half of an ACK slot: driven (target ACK) or received (RD_ACK).
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    tx_next      = tx_reg;
    ptr_next     = ptr_reg;
    rw_next      = rw_reg;
    ack_on_next  = ack_on_reg;
    sda_oe_next  = sda_oe_reg;
    ctrl_next    = ctrl_reg;
    led_next     = led_reg;
    snap         = 1'b0;
    rx_byte      = {shift_reg, sda_lvl};

    if (start) begin
      state_next   = ADDR;
      bit_cnt_next = 3'd0;
      ack_on_next  = 1'b0;
      sda_oe_next  = 1'b0;
    end else if (stop) begin
      state_next  = IDLE;
      ack_on_next = 1'b0;
      sda_oe_next = 1'b0;
    end else begin
      case (state_reg)
        ADDR, PTR, WR: begin
          if (scl_rise) begin
            shift_next   = rx_byte[6:0];
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              ack_on_next = 1'b0;
              if (state_reg == ADDR) begin
                rw_next    = rx_byte[0];
                state_next = (rx_byte[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
              end else if (state_reg == PTR) begin
                ptr_next   = rx_byte[2:0];
                state_next = PTR_ACK;
              end else begin
                if (ptr_reg == REG_CTRL) ctrl_next = rx_byte & CTRL_WR_MASK;
                if (ptr_reg == REG_LED)  led_next  = rx_byte[3:0];
                ptr_next   = ptr_reg + 3'd1;
                state_next = WR_ACK;
              end
            end
          end
        end
        ADDR_ACK, PTR_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!ack_on_reg) begin
              sda_oe_next = 1'b1;
              ack_on_next = 1'b1;
            end else begin
              ack_on_next  = 1'b0;
              bit_cnt_next = 3'd0;
              if (state_reg == ADDR_ACK && rw_reg) begin
                snap        = 1'b1;
                tx_next     = rd_byte[6:0];
                sda_oe_next = ~rd_byte[7];
                ptr_next    = ptr_reg + 3'd1;
                state_next  = RD;
              end else begin
                sda_oe_next = 1'b0;
                state_next  = (state_reg == ADDR_ACK) ? PTR : WR;
              end
            end
          end
        end
        RD: begin
          if (scl_rise) begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              ack_on_next = 1'b0;
              state_next  = RD_ACK;
            end
          end else if (scl_fall) begin
            tx_next     = {tx_reg[5:0], 1'b0};
            sda_oe_next = ~tx_reg[6];
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_lvl) ack_on_next = 1'b1;
            else          state_next  = IGNORE;
          end else if (scl_fall) begin
            if (ack_on_reg) begin
              snap         = 1'b1;
              ack_on_next  = 1'b0;
              bit_cnt_next = 3'd0;
              tx_next      = rd_byte[6:0];
              sda_oe_next  = ~rd_byte[7];
              ptr_next     = ptr_reg + 3'd1;
              state_next   = RD;
            end else begin
              sda_oe_next = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe = sda_oe_reg;
  assign ctrl   = ctrl_reg;
  assign led    = led_reg;

endmodule

// File: tb/tb_sfp_i2c_target.sv
// Bench for sfp_i2c_target: bit-banged I2C controller, transaction-level register
// model, and a per-cycle compare process on sda_oe/ctrl/led.
module tb_sfp_i2c_target;

  localparam int Q = 12;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic scl_drv = 1'b1;
  logic sda_drv = 1'b1;
  logic sfp1_mod_abs = 1'b0, sfp1_rxlos = 1'b0, sfp2_mod_abs = 1'b0, sfp2_rxlos = 1'b0;
  logic sda_oe;
  logic [7:0] ctrl;
  logic [3:0] led;
  logic sda_bus;
  assign sda_bus = sda_drv & ~sda_oe;

  int n_cmp = 0;
  int n_fail = 0;
  int oe_hi_cnt = 0;

  logic [7:0] m_ctrl = 8'h33;
  logic [3:0] m_led = 4'h0;
  logic [2:0] m_ptr = 3'd0;
  logic [7:0] m_evt = 8'h00;
  logic       exp_oe = 1'b0;
  bit         oe_valid = 1'b0;
  bit         reg_valid = 1'b0;
  int         glitch_bit = -1;
  logic [7:0] wbuf [4];
  logic [7:0] rbuf [4];

  sfp_i2c_target dut (
    .clk(clk), .nrst(nrst), .scl_i(scl_drv), .sda_i(sda_bus), .sda_oe(sda_oe),
    .sfp1_mod_abs(sfp1_mod_abs), .sfp1_rxlos(sfp1_rxlos),
    .sfp2_mod_abs(sfp2_mod_abs), .sfp2_rxlos(sfp2_rxlos),
    .ctrl(ctrl), .led(led)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) if (sda_oe === 1'b1) oe_hi_cnt++;

  always @(negedge clk) begin
    if (oe_valid) check("sda_oe", sda_oe, exp_oe);
    if (reg_valid) begin
      check("ctrl", ctrl, m_ctrl);
      check("led", led, m_led);
    end
  end

  function automatic logic [7:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return 8'hC1;
      3'd1: return {6'b0, sfp1_rxlos, sfp1_mod_abs};
      3'd2: return {6'b0, sfp2_rxlos, sfp2_mod_abs};
      3'd3: return m_ctrl;
      3'd4: return {4'b0, m_led};
`ifdef SFP_I2C_TARGET_EVENT_EN
      3'd5: return m_evt;
`endif
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_write(input logic [2:0] a, input logic [7:0] d);
    if (a == 3'd3) m_ctrl = d & 8'h77;
    else if (a == 3'd4) m_led = d[3:0];
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    oe_valid = 1'b0;
    sda_drv = 1'b1;
    clk_wait(Q);
    scl_drv = 1'b1;
    clk_wait(Q);
    sda_drv = 1'b0;
    clk_wait(Q);
    scl_drv = 1'b0;
  endtask

  task automatic i2c_stop();
    oe_valid = 1'b0;
    clk_wait(Q);
    sda_drv = 1'b0;
    clk_wait(Q);
    scl_drv = 1'b1;
    clk_wait(Q);
    sda_drv = 1'b1;
    clk_wait(Q);
    exp_oe = 1'b0;
    oe_valid = 1'b1;
    clk_wait(Q);
  endtask

  // One SCL period starting with SCL low; e_oe is what the target must drive.
  task automatic i2c_bit(input logic drv, input logic e_oe, input bit do_glitch, output logic seen);
    clk_wait(Q);
    sda_drv = drv;
    exp_oe = e_oe;
    oe_valid = 1'b1;
    clk_wait(Q);
    scl_drv = 1'b1;
    clk_wait(Q / 2);
    if (do_glitch) begin
      scl_drv = 1'b0;
      clk_wait(2);
      scl_drv = 1'b1;
    end
    clk_wait(Q / 2);
    seen = sda_bus;
    clk_wait(Q);
    scl_drv = 1'b0;
    oe_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ack_exp, input int gbit, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], 1'b0, (i == gbit), s);
    i2c_bit(1'b1, ack_exp, 1'b0, s);
    acked = ~s;
  endtask

  task automatic recv_byte(input logic [7:0] e, input bit ack, output logic [7:0] got);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, ~e[i], 1'b0, s);
      got[i] = s;
    end
    i2c_bit(~ack, 1'b0, 1'b0, s);
  endtask

  task automatic tx_write(input logic [6:0] a, input logic [2:0] p, input int n, input bit do_stop);
    logic ack;
    bit   match;
    match = (a == 7'h42);
    i2c_start();
    send_byte({a, 1'b0}, match, -1, ack);
    check("addr_ack", ack, match);
    send_byte({5'b0, p}, match, -1, ack);
    check("ptr_ack", ack, match);
    if (match) m_ptr = p;
    for (int k = 0; k < n; k++) begin
      reg_valid = 1'b0;
      send_byte(wbuf[k], match, (k == 0) ? glitch_bit : -1, ack);
      check("data_ack", ack, match);
      if (match) begin
        m_write(m_ptr, wbuf[k]);
        m_ptr = m_ptr + 3'd1;
      end
      reg_valid = 1'b1;
    end
    $display("write addr=0x%02h ptr=%0d n=%0d match=%0d", a, p, n, match);
    if (do_stop) i2c_stop();
  endtask

  task automatic tx_read(input int n);
    logic       ack;
    logic [7:0] e, got;
    i2c_start();
    send_byte({7'h42, 1'b1}, 1'b1, -1, ack);
    check("rd_addr_ack", ack, 1'b1);
    for (int k = 0; k < n; k++) begin
      e = m_read(m_ptr);
      if (m_ptr == 3'd5) m_evt = 8'h00;
      m_ptr = m_ptr + 3'd1;
      recv_byte(e, k < n - 1, got);
      check("rd_data", got, e);
      rbuf[k] = got;
    end
    $display("read n=%0d first=0x%02h", n, rbuf[0]);
    i2c_stop();
  endtask

  task automatic set_status(input logic [3:0] s);
    logic [3:0] d;
    d = s ^ {sfp2_rxlos, sfp2_mod_abs, sfp1_rxlos, sfp1_mod_abs};
    m_evt = m_evt | {2'b00, d[3:2], 2'b00, d[1:0]};
    {sfp2_rxlos, sfp2_mod_abs, sfp1_rxlos, sfp1_mod_abs} = s;
    $display("status set to 0x%0h", s);
    clk_wait(8);
  endtask

  initial begin
    logic [6:0] a;
    logic [2:0] p;
    logic       ack;
    logic [7:0] got;
    int         n, hi0;

    clk_wait(5);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_ctrl", ctrl, 8'h33);
    check("rst_led", led, 4'h0);
    nrst = 1'b1;
    clk_wait(5);
    reg_valid = 1'b1;
    exp_oe = 1'b0;
    oe_valid = 1'b1;

    wbuf[0] = 8'h05;
    tx_write(7'h42, 3'd3, 1, 1'b1);
    check("lit_ctrl_05", ctrl, 8'h05);
    check("lit_led_0", led, 4'h0);

    set_status(4'b0001);
    tx_write(7'h42, 3'd0, 0, 1'b0);
    tx_read(2);
    check("lit_rd_id", rbuf[0], 8'hC1);
    check("lit_rd_sfp1", rbuf[1], 8'h01);
    check("lit_released", sda_oe, 1'b0);

    hi0 = oe_hi_cnt;
    wbuf[0] = 8'hFF;
    tx_write(7'h48, 3'd3, 1, 1'b1);
    check("lit_nomatch_oe", oe_hi_cnt - hi0, 0);
    check("lit_nomatch_ctrl", ctrl, 8'h05);

    tx_write(7'h42, 3'd7, 0, 1'b0);
    tx_read(2);
    check("lit_rd_ptr7", rbuf[0], 8'h00);
    check("lit_rd_wrap", rbuf[1], 8'hC1);

    wbuf[0] = 8'h0A;
    glitch_bit = 4;
    tx_write(7'h42, 3'd4, 1, 1'b1);
    glitch_bit = -1;
    check("lit_glitch_led", led, 4'hA);

    tx_write(7'h42, 3'd3, 0, 1'b0);
    i2c_start();
    send_byte({7'h42, 1'b1}, 1'b1, -1, ack);
    check("rst_rd_ack", ack, 1'b1);
    clk_wait(Q);
    check("lit_drive0", sda_oe, 1'b1);
    reg_valid = 1'b0;
    nrst = 1'b0;
    #1;
    check("lit_async_oe", sda_oe, 1'b0);
    check("lit_async_ctrl", ctrl, 8'h33);
    $display("async reset asserted mid-read");
    scl_drv = 1'b1;
    sda_drv = 1'b1;
    m_ctrl = 8'h33;
    m_led = 4'h0;
    m_ptr = 3'd0;
    m_evt = {2'b00, sfp2_rxlos, sfp2_mod_abs, 2'b00, sfp1_rxlos, sfp1_mod_abs};
    clk_wait(10);
    nrst = 1'b1;
    clk_wait(10);
    reg_valid = 1'b1;
    exp_oe = 1'b0;
    oe_valid = 1'b1;

    tx_write(7'h42, 3'd5, 0, 1'b0);
    tx_read(1);
    set_status(4'b1001);
    tx_write(7'h42, 3'd5, 0, 1'b0);
    tx_read(1);
    got = rbuf[0];
    tx_write(7'h42, 3'd5, 0, 1'b0);
    tx_read(1);
`ifdef SFP_I2C_TARGET_EVENT_EN
    check("lit_evt_set", got, 8'h20);
`else
    check("lit_evt_set", got, 8'h00);
`endif
    check("lit_evt_clr", rbuf[0], 8'h00);

    for (int it = 0; it < 20; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = 7'h42;
          if ($urandom_range(0, 3) == 0) begin
            a = 7'($urandom);
            if (a == 7'h42) a = 7'h48;
          end
          p = ($urandom_range(0, 1) == 1) ? 3'(3 + $urandom_range(0, 1)) : 3'($urandom_range(0, 7));
          n = $urandom_range(1, 3);
          for (int k = 0; k < 4; k++) wbuf[k] = 8'($urandom);
          tx_write(a, p, n, 1'b1);
        end
        1: begin
          tx_write(7'h42, 3'($urandom_range(0, 7)), 0, 1'b0);
          tx_read($urandom_range(1, 3));
        end
        2: tx_read($urandom_range(1, 3));
        default: set_status(4'($urandom));
      endcase
    end

    oe_valid = 1'b0;
    reg_valid = 1'b0;
    clk_wait(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
